// File: rtl/lif_network.sv
// Leaky integrate-and-fire neuron layer with leak, refractory period,
// runtime-writable weight matrix and optional winner-take-all inhibition.
module lif_network #(
    parameter int NUM_INPUTS  = 4,
    parameter int NUM_OUTPUTS = 4,
    parameter int WEIGHT_SIZE = 4,
    parameter int POT_SIZE    = 8,
    parameter int THRESH      = 15,
    parameter int RESET       = 0,
    parameter int LEAK        = 1,
    parameter int REFRACT     = 2,
    parameter int INIT_WEIGHT = 4,
    parameter int WTA         = 0
) (
    input  logic                                                  clk,
    input  logic                                                  rst,
    input  logic                                                  step_en,
    input  logic [NUM_INPUTS-1:0]                                 spike_in,
    input  logic                                                  w_we,
    input  logic [$clog2(NUM_INPUTS > 1 ? NUM_INPUTS : 2)-1:0]    w_in_idx,
    input  logic [$clog2(NUM_OUTPUTS > 1 ? NUM_OUTPUTS : 2)-1:0]  w_out_idx,
    input  logic [WEIGHT_SIZE-1:0]                                w_data,
    output logic [NUM_OUTPUTS-1:0]                                spike_out
);

    localparam int SW = WEIGHT_SIZE + $clog2(NUM_INPUTS) + 1;
    localparam int NW = ((POT_SIZE > SW) ? POT_SIZE : SW) + 2;
    localparam int RW = (REFRACT > 0) ? $clog2(REFRACT + 1) : 1;

    localparam logic [POT_SIZE-1:0]    V_RST  = POT_SIZE'(RESET);
    localparam logic [RW-1:0]          R_LOAD = RW'(REFRACT);
    localparam logic [RW-1:0]          R_ONE  = RW'(1);
    localparam logic [WEIGHT_SIZE-1:0] W_INIT = WEIGHT_SIZE'(INIT_WEIGHT);
    localparam logic signed [NW-1:0]   LEAK_S = NW'(LEAK);
    localparam logic signed [NW-1:0]   VMAX_S = NW'({POT_SIZE{1'b1}});

    logic [WEIGHT_SIZE-1:0] w_q [NUM_INPUTS][NUM_OUTPUTS];
    logic [POT_SIZE-1:0]    v_q [NUM_OUTPUTS];
    logic [POT_SIZE-1:0]    v_d [NUM_OUTPUTS];
    logic [RW-1:0]          r_q [NUM_OUTPUTS];
    logic [RW-1:0]          r_d [NUM_OUTPUTS];
    logic [NUM_OUTPUTS-1:0] spike_q;
    logic [NUM_OUTPUTS-1:0] spike_d;

    logic [SW-1:0]          sum     [NUM_OUTPUTS];
    logic signed [NW-1:0]   nxt     [NUM_OUTPUTS];
    logic [POT_SIZE-1:0]    clamp_v [NUM_OUTPUTS];
    logic [NUM_OUTPUTS-1:0] cand;
    logic                   won;

    // Signed headroom of two bits lets the leak pull below zero before clamping.
    always_comb begin
        cand = '0;
        for (int unsigned j = 0; j < NUM_OUTPUTS; j++) begin
            sum[j] = '0;
            for (int unsigned i = 0; i < NUM_INPUTS; i++) begin
                if (spike_in[i]) begin
                    sum[j] = sum[j] + SW'(w_q[i][j]);
                end
            end
            nxt[j] = $signed(NW'(v_q[j])) + $signed(NW'(sum[j])) - LEAK_S;
            if (nxt[j] < 0) begin
                clamp_v[j] = '0;
            end else if (nxt[j] > VMAX_S) begin
                clamp_v[j] = '1;
            end else begin
                clamp_v[j] = POT_SIZE'(nxt[j]);
            end
            cand[j] = (r_q[j] == '0) && (32'(clamp_v[j]) >= 32'(THRESH));
        end
    end

    always_comb begin
        v_d     = v_q;
        r_d     = r_q;
        spike_d = '0;
        won     = 1'b0;
        if (step_en) begin
            for (int unsigned j = 0; j < NUM_OUTPUTS; j++) begin
                if (r_q[j] != '0) begin
                    r_d[j] = r_q[j] - R_ONE;
                    v_d[j] = V_RST;
                end else if (cand[j] && ((WTA == 0) || !won)) begin
                    spike_d[j] = 1'b1;
                    v_d[j]     = V_RST;
                    r_d[j]     = R_LOAD;
                    won        = 1'b1;
                end else if ((WTA != 0) && (cand != '0)) begin
                    v_d[j] = V_RST;
                end else begin
                    v_d[j] = clamp_v[j];
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int unsigned i = 0; i < NUM_INPUTS; i++) begin
                for (int unsigned j = 0; j < NUM_OUTPUTS; j++) begin
                    w_q[i][j] <= W_INIT;
                end
            end
            for (int unsigned j = 0; j < NUM_OUTPUTS; j++) begin
                v_q[j] <= V_RST;
                r_q[j] <= '0;
            end
            spike_q <= '0;
        end else begin
            v_q     <= v_d;
            r_q     <= r_d;
            spike_q <= spike_d;
            if (w_we && (32'(w_in_idx) < 32'(NUM_INPUTS)) && (32'(w_out_idx) < 32'(NUM_OUTPUTS))) begin
                w_q[w_in_idx][w_out_idx] <= w_data;
            end
        end
    end

    assign spike_out = spike_q;

endmodule

// File: tb/tb_lif_network.sv
// Scoreboard bench: three configurations (default, winner-take-all, 4-bit
// saturating with no refractory) share stimulus and are checked against a model.
module tb_lif_network;

    logic       clk;
    logic       rst;
    logic       step_en;
    logic [3:0] spike_in;
    logic       w_we;
    logic [1:0] w_in_idx;
    logic [1:0] w_out_idx;
    logic [3:0] w_data;
    logic [3:0] so0, so1, so2;

    int n_checks = 0;
    int n_fail   = 0;

    logic [11:0] expq[$];

    int mv [3][4];
    int mr [3][4];
    int mw [3][4][4];
    int potmax [3] = '{255, 255, 15};
    int thr    [3] = '{15, 15, 15};
    int refr   [3] = '{2, 2, 0};
    int wta    [3] = '{0, 1, 0};

    lif_network dut0 (
        .clk(clk), .rst(rst), .step_en(step_en), .spike_in(spike_in), .w_we(w_we),
        .w_in_idx(w_in_idx), .w_out_idx(w_out_idx), .w_data(w_data), .spike_out(so0)
    );

    lif_network #(.WTA(1)) dut1 (
        .clk(clk), .rst(rst), .step_en(step_en), .spike_in(spike_in), .w_we(w_we),
        .w_in_idx(w_in_idx), .w_out_idx(w_out_idx), .w_data(w_data), .spike_out(so1)
    );

    lif_network #(.POT_SIZE(4), .THRESH(15), .REFRACT(0)) dut2 (
        .clk(clk), .rst(rst), .step_en(step_en), .spike_in(spike_in), .w_we(w_we),
        .w_in_idx(w_in_idx), .w_out_idx(w_out_idx), .w_data(w_data), .spike_out(so2)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [3:0] act, input logic [3:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: spike_out=%b expected %b at %0t", name, act, exp, $time);
        end
    endtask

    function automatic void model_reset(input int k);
        for (int j = 0; j < 4; j++) begin
            mv[k][j] = 0;
            mr[k][j] = 0;
            for (int i = 0; i < 4; i++) mw[k][i][j] = 4;
        end
    endfunction

    function automatic logic [3:0] model_step(input int k, input logic rv, input logic se,
                                              input logic [3:0] sp, input logic we,
                                              input int wi, input int wo, input int wd);
        logic [3:0] fire;
        int  nxt [4];
        bit  cand [4];
        bit  inref [4];
        int  winner;
        fire = '0;
        if (!rv) begin
            model_reset(k);
            return fire;
        end
        if (se) begin
            winner = -1;
            for (int j = 0; j < 4; j++) begin
                inref[j] = (mr[k][j] != 0);
                cand[j]  = 0;
                nxt[j]   = 0;
                if (!inref[j]) begin
                    int s = 0;
                    for (int i = 0; i < 4; i++) if (sp[i]) s += mw[k][i][j];
                    nxt[j] = mv[k][j] + s - 1;
                    if (nxt[j] < 0) nxt[j] = 0;
                    if (nxt[j] > potmax[k]) nxt[j] = potmax[k];
                    cand[j] = (nxt[j] >= thr[k]);
                    if (cand[j] && winner < 0) winner = j;
                end
            end
            for (int j = 0; j < 4; j++) begin
                if (inref[j]) begin
                    mr[k][j] -= 1;
                    mv[k][j] = 0;
                end else if (cand[j] && (wta[k] == 0 || j == winner)) begin
                    fire[j]  = 1'b1;
                    mv[k][j] = 0;
                    mr[k][j] = refr[k];
                end else if (wta[k] != 0 && winner >= 0) begin
                    mv[k][j] = 0;
                end else begin
                    mv[k][j] = nxt[j];
                end
            end
        end
        if (we) mw[k][wi][wo] = wd;
        return fire;
    endfunction

    task automatic cyc(input logic rv, input logic se, input logic [3:0] sp, input logic we,
                       input logic [1:0] wi, input logic [1:0] wo, input logic [3:0] wd);
        logic [11:0] e;
        @(negedge clk);
        rst = rv; step_en = se; spike_in = sp;
        w_we = we; w_in_idx = wi; w_out_idx = wo; w_data = wd;
        e[3:0]  = model_step(0, rv, se, sp, we, int'(wi), int'(wo), int'(wd));
        e[7:4]  = model_step(1, rv, se, sp, we, int'(wi), int'(wo), int'(wd));
        e[11:8] = model_step(2, rv, se, sp, we, int'(wi), int'(wo), int'(wd));
        expq.push_back(e);
    endtask

    task automatic step(input logic [3:0] sp);
        cyc(1'b1, 1'b1, sp, 1'b0, 2'd0, 2'd0, 4'd0);
    endtask

    // Async reset asserted mid-cycle while a fire pulse is being presented.
    task automatic mid_reset();
        @(negedge clk);
        rst = 1'b0; step_en = 1'b0; w_we = 1'b0;
        #1;
        chk("async_reset_dut0", so0, 4'b0000);
        chk("async_reset_dut1", so1, 4'b0000);
        chk("async_reset_dut2", so2, 4'b0000);
        for (int k = 0; k < 3; k++) model_reset(k);
        expq.push_back(12'h000);
    endtask

    initial begin : monitor
        logic [11:0] e;
        forever begin
            @(posedge clk);
            #1;
            if (expq.size() > 0) begin
                e = expq.pop_front();
                chk("spike_dut0_default", so0, e[3:0]);
                chk("spike_dut1_wta", so1, e[7:4]);
                chk("spike_dut2_sat", so2, e[11:8]);
            end
        end
    end

    initial begin : driver
        rst = 1'b0; step_en = 1'b0; spike_in = '0;
        w_we = 1'b0; w_in_idx = '0; w_out_idx = '0; w_data = '0;
        for (int k = 0; k < 3; k++) model_reset(k);

        cyc(1'b0, 1'b0, 4'd0, 1'b0, 2'd0, 2'd0, 4'd0);
        cyc(1'b0, 1'b0, 4'd0, 1'b0, 2'd0, 2'd0, 4'd0);

        repeat (12) step(4'b0001);

        cyc(1'b0, 1'b0, 4'd0, 1'b0, 2'd0, 2'd0, 4'd0);
        repeat (10) step(4'b0000);

        cyc(1'b1, 1'b0, 4'd0, 1'b1, 2'd1, 2'd2, 4'd15);
        repeat (2) step(4'b0010);

        repeat (3) step(4'b0001);
        cyc(1'b0, 1'b0, 4'd0, 1'b0, 2'd0, 2'd0, 4'd0);
        repeat (5) step(4'b0001);
        mid_reset();
        cyc(1'b0, 1'b0, 4'd0, 1'b0, 2'd0, 2'd0, 4'd0);

        cyc(1'b1, 1'b0, 4'd0, 1'b1, 2'd0, 2'd1, 4'd15);
        cyc(1'b1, 1'b0, 4'd0, 1'b1, 2'd0, 2'd3, 4'd15);
        repeat (4) step(4'b0001);

        cyc(1'b1, 1'b1, 4'b1111, 1'b1, 2'd3, 2'd0, 4'd15);
        repeat (3) step(4'b1111);

        for (int n = 0; n < 400; n++) begin
            logic rv, se, we;
            rv = ($urandom_range(99) != 0);
            se = ($urandom_range(3) != 0);
            we = ($urandom_range(4) == 0);
            cyc(rv, se, 4'($urandom), we, 2'($urandom), 2'($urandom), 4'($urandom));
        end

        cyc(1'b1, 1'b0, 4'd0, 1'b0, 2'd0, 2'd0, 4'd0);
        cyc(1'b1, 1'b0, 4'd0, 1'b0, 2'd0, 2'd0, 4'd0);
        @(posedge clk);
        #2;
        n_checks++;
        if (expq.size() != 0) begin
            n_fail++;
            $display("FAIL scoreboard_drain: %0d entries left, expected 0", expq.size());
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
